// File: rtl/loop_osc_monitor.sv
// Observes the far ends of a combinational feedback loop after a start pulse and
// classifies it as settled, oscillating with a detected period, or unresolved.
module loop_osc_monitor #(
    parameter int WIDTH      = 9,
    parameter int MAX_PERIOD = 8,
    parameter int STABLE_CYC = 16,
    parameter int CONFIRM    = 16,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] net_in,
    output logic             busy,
    output logic             done,
    output logic             stable,
    output logic             oscillating,
    output logic [3:0]       period,
    output logic [CNT_W-1:0] toggle_cnt
);
    localparam int RUN_W   = $clog2(CONFIRM + 1);
    localparam int FILL_W  = (MAX_PERIOD > 2) ? $clog2(MAX_PERIOD) : 1;
    localparam int WATCH_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [RUN_W-1:0]   STABLE_TH  = RUN_W'(STABLE_CYC);
    localparam logic [RUN_W-1:0]   CONFIRM_TH = RUN_W'(CONFIRM);
    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(MAX_PERIOD - 1);
    localparam logic [WATCH_W-1:0] WATCH_LAST = WATCH_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FILL, WATCH, DONE} state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   hist     [MAX_PERIOD];
    logic [RUN_W-1:0]   run      [1:MAX_PERIOD];
    logic [RUN_W-1:0]   run_next [1:MAX_PERIOD];
    logic [FILL_W-1:0]  fill_cnt;
    logic [WATCH_W-1:0] watch_cnt;
    logic               hit_stable, hit_osc, hit_timeout, toggled;
    logic [3:0]         osc_period;

    // run[p] counts consecutive samples equal to the one p clocks earlier; the
    // decision looks at these updated values, not the registered ones.
    always_comb begin
        hit_stable  = 1'b0;
        hit_osc     = 1'b0;
        osc_period  = 4'd0;
        toggled     = (net_in != hist[0]);
        hit_timeout = (watch_cnt == WATCH_LAST);
        for (int p = 1; p <= MAX_PERIOD; p++) begin
            if (net_in == hist[p-1])
                run_next[p] = (run[p] == CONFIRM_TH) ? run[p] : run[p] + 1'b1;
            else
                run_next[p] = '0;
        end
        hit_stable = (run_next[1] >= STABLE_TH);
        for (int p = MAX_PERIOD; p >= 2; p--) begin
            if (run_next[p] >= CONFIRM_TH) begin
                hit_osc    = 1'b1;
                osc_period = 4'(p);
            end
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state == FILL) || (state == WATCH);
        case (state)
            IDLE, DONE: if (start) state_next = FILL;
            FILL:       if (fill_cnt == FILL_LAST) state_next = WATCH;
            WATCH:      if (hit_stable || hit_osc || hit_timeout) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MAX_PERIOD; k++) hist[k] <= '0;
            for (int p = 1; p <= MAX_PERIOD; p++) run[p] <= '0;
            fill_cnt    <= '0;
            watch_cnt   <= '0;
            toggle_cnt  <= '0;
            stable      <= 1'b0;
            oscillating <= 1'b0;
            period      <= 4'd0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == FILL || state == WATCH) begin
                hist[0] <= net_in;
                for (int k = 1; k < MAX_PERIOD; k++) hist[k] <= hist[k-1];
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        for (int p = 1; p <= MAX_PERIOD; p++) run[p] <= '0;
                        fill_cnt    <= '0;
                        watch_cnt   <= '0;
                        toggle_cnt  <= '0;
                        stable      <= 1'b0;
                        oscillating <= 1'b0;
                        period      <= 4'd0;
                    end
                end
                FILL: fill_cnt <= fill_cnt + 1'b1;
                WATCH: begin
                    for (int p = 1; p <= MAX_PERIOD; p++) run[p] <= run_next[p];
                    watch_cnt <= watch_cnt + 1'b1;
                    if (toggled && (toggle_cnt != '1))
                        toggle_cnt <= toggle_cnt + 1'b1;
                    // Stable wins over oscillation because a constant also matches every p.
                    if (hit_stable) begin
                        stable <= 1'b1;
                        done   <= 1'b1;
                    end else if (hit_osc) begin
                        oscillating <= 1'b1;
                        period      <= osc_period;
                        done        <= 1'b1;
                    end else if (hit_timeout) begin
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_loop_osc_monitor.sv
// Directed, table-driven bench for loop_osc_monitor: each vector runs one full
// measurement and compares the verdict, its timing and the toggle count.
module tb_loop_osc_monitor;
    logic       clk = 1'b0;
    logic       rst, start;
    logic [8:0] net_in;
    logic       busy, done, stable, oscillating;
    logic [3:0] period;
    logic [7:0] toggle_cnt;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    loop_osc_monitor dut (
        .clk(clk), .rst(rst), .start(start), .net_in(net_in),
        .busy(busy), .done(done), .stable(stable), .oscillating(oscillating),
        .period(period), .toggle_cnt(toggle_cnt)
    );

    typedef struct {
        int mode;
        bit busy_start;
        int exp_edge;
        bit exp_stable;
        bit exp_osc;
        int exp_period;
        int exp_toggle;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Value of net_in sampled at edge T0+n for each stimulus mode.
    function automatic logic [8:0] pattern(input int mode, input int n, input logic [8:0] lf);
        case (mode)
            0:       return 9'h1FF;
            1:       return (n % 2 != 0) ? 9'h1FF : 9'h000;
            2:       return {8'h00, (n % 6) >= 3};
            3:       return {8'h00, (n % 3) != 0};
            4:       return ((n % 2 != 0) ? 9'h1FF : 9'h000) | ((n == 18) ? 9'h010 : 9'h000);
            default: return lf;
        endcase
    endfunction

    task automatic applyStimulus(input int idx, input vec_t v);
        int         done_edge = -1;
        logic [8:0] lf = 9'h001;
        start  = 1'b1;
        net_in = pattern(v.mode, 0, lf);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput($sformatf("v%0d_start_busy", idx), busy, 1);
        checkOutput($sformatf("v%0d_start_clear", idx),
                    {stable, oscillating, period, toggle_cnt}, 0);
        for (int n = 1; n <= 100 && done_edge < 0; n++) begin
            lf     = {lf[7:0], lf[8] ^ lf[4]};
            net_in = pattern(v.mode, n, lf);
            start  = v.busy_start && (n == 5 || n == 15);
            @(posedge clk); #1;
            if (done) done_edge = n;
        end
        start = 1'b0;
        checkOutput($sformatf("v%0d_done_edge", idx), done_edge, v.exp_edge);
        checkOutput($sformatf("v%0d_stable", idx), stable, int'(v.exp_stable));
        checkOutput($sformatf("v%0d_oscillating", idx), oscillating, int'(v.exp_osc));
        checkOutput($sformatf("v%0d_period", idx), period, v.exp_period);
        checkOutput($sformatf("v%0d_toggle_cnt", idx), toggle_cnt, v.exp_toggle);
        @(posedge clk); #1;
        checkOutput($sformatf("v%0d_done_one_cycle", idx), done, 0);
        checkOutput($sformatf("v%0d_idle_busy", idx), busy, 0);
        checkOutput($sformatf("v%0d_held", idx),
                    {stable, oscillating, period, toggle_cnt},
                    {v.exp_stable, v.exp_osc, 4'(v.exp_period), 8'(v.exp_toggle)});
    endtask

    initial begin
        int done_seen;
        // mode, busy_start, verdict edge, stable, osc, period, toggles
        vecs[0] = '{0, 1'b0, 24, 1'b1, 1'b0, 0, 0};
        vecs[1] = '{1, 1'b0, 24, 1'b0, 1'b1, 2, 16};
        vecs[2] = '{2, 1'b0, 24, 1'b0, 1'b1, 6, 6};
        vecs[3] = '{3, 1'b0, 24, 1'b0, 1'b1, 3, 11};
        vecs[4] = '{4, 1'b0, 36, 1'b0, 1'b1, 2, 28};
        vecs[5] = '{5, 1'b0, 72, 1'b0, 1'b0, 0, 64};
        vecs[6] = '{0, 1'b1, 24, 1'b1, 1'b0, 0, 0};
        vecs[7] = '{1, 1'b1, 24, 1'b0, 1'b1, 2, 16};

        rst = 1'b1; start = 1'b0; net_in = 9'h000;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_verdicts", {stable, oscillating, period}, 0);
        checkOutput("reset_toggle", toggle_cnt, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);

        // Abort a measurement with reset partway through WATCH.
        start = 1'b1; net_in = 9'h000;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            net_in = (n % 2 != 0) ? 9'h1FF : 9'h000;
            @(posedge clk); #1;
        end
        checkOutput("pre_rst_busy", busy, 1);
        checkOutput("pre_rst_toggle", toggle_cnt, 4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("mid_rst_outputs",
                    {busy, done, stable, oscillating, period, toggle_cnt}, 0);
        done_seen = 0;
        for (int n = 0; n < 30; n++) begin
            net_in = (n % 2 != 0) ? 9'h1FF : 9'h000;
            @(posedge clk); #1;
            if (done) done_seen = 1;
        end
        checkOutput("mid_rst_no_done", done_seen, 0);
        checkOutput("mid_rst_stays_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
